// File: rtl/thread_scheduler.sv
// Round-robin scheduler holding one PC per hardware thread; offers one eligible
// thread per cycle to fetch/issue and retires threads on halting writeback.
module thread_scheduler #(
    parameter int NUM_THREADS = 4,
    parameter int TID_WIDTH   = 2,
    parameter int PC_WIDTH    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [PC_WIDTH-1:0]    start_pc,
    input  logic [NUM_THREADS-1:0] thread_mask,
    output logic                   issue_valid,
    output logic [TID_WIDTH-1:0]   issue_tid,
    output logic [PC_WIDTH-1:0]    issue_pc,
    input  logic                   issue_ready,
    input  logic                   wb_valid,
    input  logic [TID_WIDTH-1:0]   wb_tid,
    input  logic                   wb_branch,
    input  logic [PC_WIDTH-1:0]    wb_target,
    input  logic                   wb_halt,
    output logic [NUM_THREADS-1:0] thread_active,
    output logic                   busy,
    output logic                   halt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q [NUM_THREADS];
    logic [PC_WIDTH-1:0]    pc_d [NUM_THREADS];
    logic [NUM_THREADS-1:0] active_q, active_d;
    logic [NUM_THREADS-1:0] pending_q, pending_d;
    logic [TID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NUM_THREADS-1:0] eligible;
    logic [TID_WIDTH-1:0]   scan_idx;
    logic [TID_WIDTH-1:0]   sel_tid;
    logic                   found;
    logic                   transfer;

    assign busy          = (state_q == ST_RUN);
    assign halt          = (state_q == ST_DONE);
    assign thread_active = active_q;

    // Rotating priority scan starting at rr_ptr; index wraps naturally in TID_WIDTH bits.
    always_comb begin
        eligible = active_q & ~pending_q;
        scan_idx = '0;
        sel_tid  = '0;
        found    = 1'b0;
        for (int unsigned k = 0; k < NUM_THREADS; k++) begin
            scan_idx = rr_ptr_q + TID_WIDTH'(k);
            if (!found && eligible[scan_idx]) begin
                found   = 1'b1;
                sel_tid = scan_idx;
            end
        end
        issue_valid = busy && found;
        issue_tid   = issue_valid ? sel_tid : '0;
        issue_pc    = issue_valid ? pc_q[sel_tid] : '0;
    end

    assign transfer = issue_valid && issue_ready;

    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        pending_d = pending_q;
        rr_ptr_d  = rr_ptr_q;
        for (int unsigned i = 0; i < NUM_THREADS; i++) begin
            pc_d[i] = pc_q[i];
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (thread_mask != '0) begin
                        state_d   = ST_RUN;
                        active_d  = thread_mask;
                        pending_d = '0;
                        rr_ptr_d  = '0;
                        for (int unsigned i = 0; i < NUM_THREADS; i++) begin
                            pc_d[i] = start_pc;
                        end
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (transfer) begin
                    pending_d[issue_tid] = 1'b1;
                    rr_ptr_d             = issue_tid + 1'b1;
                end
                // A pending thread is never offered, so wb_tid cannot collide with issue_tid here.
                if (wb_valid && pending_q[wb_tid]) begin
                    pending_d[wb_tid] = 1'b0;
                    if (wb_halt) begin
                        active_d[wb_tid] = 1'b0;
                    end else if (wb_branch) begin
                        pc_d[wb_tid] = wb_target;
                    end else begin
                        pc_d[wb_tid] = pc_q[wb_tid] + 1'b1;
                    end
                end
                if ((active_d | pending_d) == '0) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            active_q  <= '0;
            pending_q <= '0;
            rr_ptr_q  <= '0;
            for (int unsigned i = 0; i < NUM_THREADS; i++) begin
                pc_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            rr_ptr_q  <= rr_ptr_d;
            for (int unsigned i = 0; i < NUM_THREADS; i++) begin
                pc_q[i] <= pc_d[i];
            end
        end
    end

endmodule

// File: doc/thread_scheduler.md
Name: thread_scheduler

Overview:
- Round-robin thread scheduler sequencing the per-thread program counters of compute_core.
- Holds one PC per thread and offers at most one ready thread per cycle to the core's fetch/issue stage with a valid/ready handshake.
- Tracks outstanding instructions per thread and retires threads on halt writeback.
- Raises core-level halt once every launched thread has finished.

Parameters:
- NUM_THREADS, 4, number of hardware threads; power of two, 2..16.
- TID_WIDTH, 2, thread-id width; equals log2(NUM_THREADS).
- PC_WIDTH, 8, program-counter width; byte-free instruction index.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- start  in  1  launch pulse; sampled only in IDLE or DONE
- start_pc  in  PC_WIDTH  initial PC loaded into every enabled thread
- thread_mask  in  NUM_THREADS  threads enabled by this launch; bit i = thread i
- issue_valid  out  1  a thread is offered for issue
- issue_tid  out  TID_WIDTH  offered thread id
- issue_pc  out  PC_WIDTH  PC of offered thread
- issue_ready  in  1  core accepts the offered instruction this cycle
- wb_valid  in  1  completion report from core
- wb_tid  in  TID_WIDTH  thread completing
- wb_branch  in  1  take wb_target as next PC
- wb_target  in  PC_WIDTH  branch target
- wb_halt  in  1  thread executed HALT
- thread_active  out  NUM_THREADS  per-thread active flags
- busy  out  1  state == RUN
- halt  out  1  state == DONE

Behaviour:
- Reset (reset == 0 at a rising edge): state = IDLE; all pc = 0; active = 0; pending = 0; rr_ptr = 0. Outputs: issue_valid = 0, issue_tid = 0, issue_pc = 0, thread_active = 0, busy = 0, halt = 0.
- Reset asserted mid-RUN behaves the same way. In-flight work is abandoned, and later wb_valid pulses are ignored while IDLE.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE + start, thread_mask != 0: next state RUN. active = thread_mask, pending = 0, pc[i] = start_pc for all i, rr_ptr = 0.
  - IDLE/DONE + start, thread_mask == 0: next state DONE.
  - RUN: start is ignored.
  - RUN -> DONE at the edge where (active | pending) becomes all-zero, evaluated on next-state values.
  - DONE holds until start or reset.
- Eligibility: eligible[i] = active[i] & ~pending[i], using registered values only.
- Issue outputs are combinational from registers only; there is no input-to-output path.
  - issue_valid = busy & |eligible.
  - issue_tid = first eligible thread scanning rr_ptr, rr_ptr+1, ... mod NUM_THREADS.
  - issue_pc = pc[issue_tid].
  - When issue_valid = 0, issue_tid and issue_pc are 0.
- Handshake: a transfer occurs when issue_valid & issue_ready. At that edge: pending[issue_tid] = 1 and rr_ptr = issue_tid + 1 (mod NUM_THREADS). Without a transfer, rr_ptr holds.
- Each thread has at most one instruction outstanding. It is not re-offered until its writeback arrives.
- Writeback (wb_valid in RUN, pending[wb_tid] == 1): pending[wb_tid] = 0.
  - wb_halt: active[wb_tid] = 0; pc unchanged. wb_halt has priority over wb_branch.
  - else wb_branch: pc = wb_target.
  - else: pc = pc + 1, wrapping modulo 2^PC_WIDTH (max value -> 0).
- Writeback for a non-pending thread, or outside RUN, is ignored entirely.
- Same-cycle issue and writeback of different threads both take effect.
- A thread whose writeback lands at edge N is eligible from cycle N+1; the earliest re-issue is one cycle after writeback.
- Latency: start sampled at edge N -> busy = 1 and issue_valid = 1 in cycle N+1 (if mask != 0).
- The halt flag rises in the cycle after the last halting writeback edge.

Test Plan:
- Launch with mask = 4'b1111, start_pc = 8'h10, issue_ready = 1, core returning a plain writeback one cycle after each issue -> issue_tid order 0,1,2,3,0,...; each thread's issue_pc goes 10,11,12...; pending blocks same-thread re-issue.
- Mask = 4'b0101, start_pc = 8'hFF -> only tids 0 and 2 are issued. First plain writeback wraps their PC to 8'h00. thread_active stays 4'b0101.
- issue_ready held 0 for 5 cycles -> issue_valid stays 1 with tid/pc stable and rr_ptr unchanged. On release, the same tid transfers first.
- Branch writeback: wb_branch = 1, wb_target = 8'h40 for tid 1 -> next issue of tid 1 shows pc 8'h40. wb_branch and wb_halt together -> thread retired, pc not updated.
- Halt each thread in turn -> thread_active decrements bitwise. halt = 1 and busy = 0 the cycle after the final halting writeback. A stray wb_valid for a non-pending tid changes nothing. start with mask = 0 -> DONE next cycle.
- reset = 0 mid-RUN with two threads pending -> all outputs zero next cycle. A following wb_valid is ignored. A new start relaunches cleanly from start_pc.
